seg_scan_decoder: RTL and testbench

//  Receives the multiplexed 7-segment bus (segments + digit select) that the sprint-timer display side drives.

---
 rtl/seg_scan_pkg.sv | 29 ++
 rtl/seg7_to_bcd.sv | 27 ++
 rtl/seg_scan_decoder.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared constants for the 7-segment scan decoder: segment
//                lookup table (bit0=a .. bit6=g), BCD codes for blank and
//                unrecognised digits, and the capture FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    localparam logic [3:0] BCD_BLANK     = 4'hF;
    localparam logic [3:0] BCD_BAD       = 4'hE;
    localparam logic [6:0] SEG_BLANK     = 7'h00;
    localparam int         NUM_SEG_CODES = 10;

    // Index i holds the segment pattern that displays decimal digit i.
    localparam logic [6:0] SEG_LUT [NUM_SEG_CODES] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg_state_e;

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_bcd
//  Description : Combinational 7-segment to BCD decoder. Known digit patterns
//                map to 0-9, an all-dark pattern maps to BCD_BLANK and any
//                other pattern maps to BCD_BAD.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd
);

    // Walk the digit table; the default covers blank and unrecognised codes.
    always_comb begin
        o_bcd = (i_seg == SEG_BLANK) ? BCD_BLANK : BCD_BAD;
        for (int i = 0; i < NUM_SEG_CODES; i++) begin
            if (i_seg == SEG_LUT[i]) begin
                o_bcd = 4'(i);
            end
        end
    end

endmodule : seg7_to_bcd
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Monitors a multiplexed 7-segment bus (segments + one-hot
//                digit select), captures each digit once its (dx,seg) pair
//                has been stable for STABLE_CYCLES cycles, and publishes the
//                recovered BCD value once every digit of a scan is captured.
//                Flags unrecognised patterns and a stalled scan.
//                Optional macro SEG_ERR_CNT_EN adds an 8-bit saturating count
//                of O_bad pulses on port O_err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4,   // effective minimum is 2
    parameter int TIMEOUT       = 1000
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic [6:0]              I_led,
    input  logic [NUM_DIGITS-1:0]   I_dx,
    output logic [4*NUM_DIGITS-1:0] O_bcd,
    output logic                    O_frame_vld,
    output logic                    O_bad,
    output logic                    O_stale
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0]              O_err_cnt
`endif
);

    localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT);

    seg_state_e                r_state;
    logic [NUM_DIGITS-1:0]     r_sample_dx;
    logic [6:0]                r_sample_led;
    logic [c_CNT_W-1:0]        r_stable_cnt;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic [NUM_DIGITS-1:0]     r_mask;
    logic [4*NUM_DIGITS-1:0]   r_bcd;
    logic                      r_frame_vld;
    logic                      r_bad;
    logic [c_TO_W-1:0]         r_to_cnt;

    logic [3:0]                w_dec;
    logic                      w_dx_valid;
    logic                      w_same;
    logic                      w_capture;
    logic                      w_mask_full;
    logic [NUM_DIGITS-1:0]     w_cap_mask;

    // Only the sampled pattern is ever captured, so decode that.
    seg7_to_bcd u_dec (
        .i_seg (r_sample_led),
        .o_bcd (w_dec)
    );

    assign w_dx_valid  = $onehot(I_dx);
    assign w_same      = (I_dx == r_sample_dx) && (I_led == r_sample_led);
    // The cycle that would bring the stable count to STABLE_CYCLES captures.
    assign w_capture   = (r_state == SETTLE) && w_same && (r_stable_cnt == c_CNT_LAST);
    assign w_mask_full = &r_mask;
    assign w_cap_mask  = w_capture ? r_sample_dx : '0;

    // Stability tracker: sample a valid digit select, count identical cycles,
    // then hold until the bus moves on (re-evaluated in that same cycle).
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state      <= IDLE;
            r_sample_dx  <= '0;
            r_sample_led <= '0;
            r_stable_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dx_valid) begin
                        r_state      <= SETTLE;
                        r_sample_dx  <= I_dx;
                        r_sample_led <= I_led;
                        r_stable_cnt <= c_CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (w_same) begin
                        r_stable_cnt <= r_stable_cnt + c_CNT_ONE;
                        if (w_capture) begin
                            r_state <= HOLD;
                        end
                    end else if (w_dx_valid) begin
                        r_sample_dx  <= I_dx;
                        r_sample_led <= I_led;
                        r_stable_cnt <= c_CNT_ONE;
                    end else begin
                        r_state      <= IDLE;
                        r_stable_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!w_same) begin
                        if (w_dx_valid) begin
                            r_state      <= SETTLE;
                            r_sample_dx  <= I_dx;
                            r_sample_led <= I_led;
                            r_stable_cnt <= c_CNT_ONE;
                        end else begin
                            r_state      <= IDLE;
                            r_stable_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_stable_cnt <= '0;
                end
            endcase
        end
    end

    // Shadow capture, captured-digit mask and frame publication; a capture
    // landing on the frame cycle seeds the next frame's mask.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_shadow    <= {NUM_DIGITS{BCD_BLANK}};
            r_mask      <= '0;
            r_bcd       <= {NUM_DIGITS{BCD_BLANK}};
            r_frame_vld <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_frame_vld <= w_mask_full;
            r_bad       <= w_capture && (w_dec == BCD_BAD);
            if (w_mask_full) begin
                r_bcd  <= r_shadow;
                r_mask <= w_cap_mask;
            end else begin
                r_mask <= r_mask | w_cap_mask;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && r_sample_dx[i]) begin
                    r_shadow[4*i +: 4] <= w_dec;
                end
            end
        end
    end

    // Frame watchdog: restarts on every published frame, saturates at TIMEOUT.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_to_cnt <= '0;
        end else if (r_frame_vld) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    assign O_bcd       = r_bcd;
    assign O_frame_vld = r_frame_vld;
    assign O_bad       = r_bad;
    assign O_stale     = (r_to_cnt == c_TO_MAX);

`ifdef SEG_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Count bad-pattern pulses, holding at the top value.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_err_cnt <= '0;
        end else if (r_bad && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign O_err_cnt = r_err_cnt;
`endif

endmodule : seg_scan_decoder
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_decoder
//  Description : Self-checking bench for seg_scan_decoder. Expected frames
//                are queued as scans are driven and checked by a monitor
//                whenever the decoder publishes a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] led = 7'h00;
    logic [1:0] dx  = 2'b00;
    logic [7:0] bcd;
    logic       frame_vld;
    logic       bad;
    logic       stale;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int         n_cmp       = 0;
    int         n_err       = 0;
    int         frames_seen = 0;
    int         bad_seen    = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    // Scan table: segment patterns and the digits they should decode to.
    logic [6:0] scan_l0 [5] = '{7'h3F, 7'h7D, 7'h07, 7'h6F, 7'h00};
    logic [6:0] scan_l1 [5] = '{7'h66, 7'h6D, 7'h7F, 7'h4F, 7'h5B};
    logic [3:0] scan_e0 [5] = '{4'h0,  4'h6,  4'h7,  4'h9,  4'hF};
    logic [3:0] scan_e1 [5] = '{4'h4,  4'h5,  4'h8,  4'h3,  4'h2};

    seg_scan_decoder #(
        .NUM_DIGITS    (2),
        .STABLE_CYCLES (4),
        .TIMEOUT       (1000)
    ) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_led       (led),
        .I_dx        (dx),
        .O_bcd       (bcd),
        .O_frame_vld (frame_vld),
        .O_bad       (bad),
        .O_stale     (stale)
`ifdef SEG_ERR_CNT_EN
        ,
        .O_err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every published frame must match the oldest expected value.
    always @(negedge clk) begin
        if (frame_vld) begin
            frames_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL frame_unexpected: got bcd=%h with no frame expected", bcd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bcd !== mon_exp) begin
                    n_err++;
                    $display("FAIL frame_value: got bcd=%h, expected %h", bcd, mon_exp);
                end
            end
        end
        if (bad) bad_seen++;
    end

    // Apply one bus value (called at a falling edge) for n rising edges.
    task automatic hold(input logic [1:0] d, input logic [6:0] l, input int n);
        dx  = d;
        led = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dx  = 2'b00;
        led = 7'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bcd !== 8'hFF) begin n_err++; $display("FAIL reset_bcd: got %h, expected ff", bcd); end
        n_cmp++;
        if (frame_vld !== 1'b0) begin n_err++; $display("FAIL reset_frame_vld: got %b, expected 0", frame_vld); end
        n_cmp++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL reset_bad: got %b, expected 0", bad); end
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL reset_stale: got %b, expected 0", stale); end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 8'h00) begin n_err++; $display("FAIL reset_err_cnt: got %h, expected 00", err_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_stale();
        bit seen = 0;
        bit prev = 0;
        hold(2'b00, 7'h00, 999);
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL stale_early: got %b after 999 idle cycles, expected 0", stale); end
        hold(2'b00, 7'h00, 1);
        n_cmp++;
        if (stale !== 1'b1) begin n_err++; $display("FAIL stale_set: got %b after 1000 idle cycles, expected 1", stale); end
        exp_q.push_back(8'h21);
        hold(2'b01, 7'h06, 10);
        dx  = 2'b10;
        led = 7'h5B;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prev) begin
                n_cmp++;
                if (stale !== 1'b0) begin n_err++; $display("FAIL stale_clear: got %b after frame, expected 0", stale); end
            end
            if (frame_vld) begin
                seen = 1;
                n_cmp++;
                if (stale !== 1'b1) begin n_err++; $display("FAIL stale_during_frame: got %b, expected 1", stale); end
            end
            prev = frame_vld;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL stale_frame_seen: got no frame, expected one"); end
        hold(2'b00, 7'h00, 3);
    endtask

    task automatic test_scan();
        int b0 = bad_seen;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({scan_e1[k], scan_e0[k]});
            hold(2'b01, scan_l0[k], 6);
            hold(2'b10, scan_l1[k], 6);
        end
        hold(2'b00, 7'h00, 4);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scan_all_frames: got %0d frames pending, expected 0", exp_q.size()); end
        n_cmp++;
        if (bcd !== 8'h2F) begin n_err++; $display("FAIL scan_last_bcd: got %h, expected 2f", bcd); end
        n_cmp++;
        if (bad_seen != b0) begin n_err++; $display("FAIL scan_no_bad: got %0d bad pulses, expected 0", bad_seen - b0); end
    endtask

    task automatic test_short_dwell();
        int f0 = frames_seen;
        hold(2'b01, 7'h06, 3);
        hold(2'b10, 7'h5B, 10);
        n_cmp++;
        if (frames_seen != f0) begin n_err++; $display("FAIL short_no_frame: got %0d frames, expected 0", frames_seen - f0); end
        exp_q.push_back(8'h23);
        hold(2'b01, 7'h4F, 10);
        hold(2'b00, 7'h00, 3);
        n_cmp++;
        if (frames_seen != f0 + 1) begin n_err++; $display("FAIL short_full_scan: got %0d frames, expected 1", frames_seen - f0); end
    endtask

    task automatic test_bad();
        int b0 = bad_seen;
        exp_q.push_back(8'h1E);
        hold(2'b01, 7'h7E, 10);
        hold(2'b10, 7'h06, 10);
        hold(2'b00, 7'h00, 3);
        n_cmp++;
        if (bad_seen != b0 + 1) begin n_err++; $display("FAIL bad_pulse: got %0d bad cycles, expected 1", bad_seen - b0); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bad_frame: got %0d frames pending, expected 0", exp_q.size()); end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 8'd1) begin n_err++; $display("FAIL bad_err_cnt: got %0d, expected 1", err_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        int f0;
        hold(2'b01, 7'h6D, 10);
        rst = 1'b1;
        dx  = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (bcd !== 8'hFF) begin n_err++; $display("FAIL rst_mid_bcd: got %h, expected ff", bcd); end
        rst = 1'b0;
        f0  = frames_seen;
        hold(2'b10, 7'h07, 10);
        hold(2'b00, 7'h00, 2);
        n_cmp++;
        if (frames_seen != f0) begin n_err++; $display("FAIL rst_mid_no_frame: got %0d frames, expected 0", frames_seen - f0); end
        exp_q.push_back(8'h74);
        hold(2'b01, 7'h66, 10);
        hold(2'b00, 7'h00, 3);
        n_cmp++;
        if (frames_seen != f0 + 1) begin n_err++; $display("FAIL rst_mid_rescan: got %0d frames, expected 1", frames_seen - f0); end
    endtask

    task automatic test_back_to_back();
        int f0 = frames_seen;
        // Digit 0 captured twice in one frame: the later value wins.
        exp_q.push_back(8'h42);
        hold(2'b01, 7'h06, 4);
        hold(2'b01, 7'h5B, 4);
        hold(2'b10, 7'h66, 4);
        exp_q.push_back(8'h98);
        hold(2'b01, 7'h7F, 4);
        hold(2'b10, 7'h6F, 4);
        exp_q.push_back(8'h10);
        hold(2'b01, 7'h3F, 4);
        hold(2'b10, 7'h06, 4);
        hold(2'b00, 7'h00, 4);
        n_cmp++;
        if (frames_seen != f0 + 3) begin n_err++; $display("FAIL b2b_frames: got %0d frames, expected 3", frames_seen - f0); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d frames pending, expected 0", exp_q.size()); end
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL b2b_stale: got %b, expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_stale();
        test_scan();
        test_short_dwell();
        test_bad();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within 500000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_seg_scan_decoder
`default_nettype wire
